// File: rtl/mips_pkg.sv
// Shared widths, funct codes, FSM and forward-select encodings for the MIPS pipeline.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int RA_W   = 5;

  localparam logic [OP_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [OP_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [OP_W-1:0] FUNCT_NOP = 6'h00;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [OP_W-1:0]   operation;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] store_data;
  } id_exe_t;

  function automatic id_exe_t bubble();
    id_exe_t b;
    b           = '0;
    b.operation = FUNCT_NOP;
    return b;
  endfunction

  // r0 is hardwired, so it can never be the target of a forward or a RAW.
  function automatic logic rd_hit(input logic en, input logic [RA_W-1:0] rd,
                                  input logic [RA_W-1:0] src);
    return en && (src != '0) && (rd == src);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic [RA_W-1:0] src,
                                        input logic ex_en,  input logic [RA_W-1:0] ex_rd,
                                        input logic mem_en, input logic [RA_W-1:0] mem_rd,
                                        input logic wb_en,  input logic [RA_W-1:0] wb_rd);
    if (rd_hit(ex_en, ex_rd, src))   return FWD_EX;
    if (rd_hit(mem_en, mem_rd, src)) return FWD_MEM;
    if (rd_hit(wb_en, wb_rd, src))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forward selects and data-hazard flag for the ID/EXE stage.
// ID_EXE_FWD_EN defined: forwarding, load-use stalls only; undefined: stall on any RAW.
module hazard_fwd_unit
  import mips_pkg::*;
(
  input  logic            id_valid,
  input  logic            id_use_imm,
  input  logic            id_mem_write,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output fwd_sel_t        rs_sel,
  output fwd_sel_t        rt_sel,
  output logic            hazard
);

  // rt is a real source for R-type ops and as store data.
  logic rt_used;
  assign rt_used = !id_use_imm || id_mem_write;

`ifdef ID_EXE_FWD_EN
  logic ex_fwd_en;
  logic load_in_ex;

  // A load in EX has no result yet, so it is never an EX forward source.
  assign ex_fwd_en  = ex_valid && ex_reg_write && !ex_mem_read;
  assign load_in_ex = ex_valid && ex_mem_read;

  assign rs_sel = fwd_pick(id_rs, ex_fwd_en, ex_rd, mem_reg_write, mem_rd,
                           wb_reg_write, wb_rd);
  assign rt_sel = fwd_pick(id_rt, ex_fwd_en, ex_rd, mem_reg_write, mem_rd,
                           wb_reg_write, wb_rd);

  assign hazard = id_valid &&
                  (rd_hit(load_in_ex, ex_rd, id_rs) ||
                   (rt_used && rd_hit(load_in_ex, ex_rd, id_rt)));
`else
  logic ex_wr_en;
  logic rs_raw;
  logic rt_raw;
  logic unused_ex_mem_read;

  assign ex_wr_en           = ex_valid && ex_reg_write;
  assign unused_ex_mem_read = ex_mem_read;

  assign rs_sel = FWD_RF;
  assign rt_sel = FWD_RF;

  assign rs_raw = rd_hit(ex_wr_en, ex_rd, id_rs) ||
                  rd_hit(mem_reg_write, mem_rd, id_rs) ||
                  rd_hit(wb_reg_write, wb_rd, id_rs);
  assign rt_raw = rd_hit(ex_wr_en, ex_rd, id_rt) ||
                  rd_hit(mem_reg_write, mem_rd, id_rt) ||
                  rd_hit(wb_reg_write, wb_rd, id_rt);

  assign hazard = id_valid && (rs_raw || (rt_used && rt_raw));
`endif

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding, load-use detection and bubble insertion.
// Outputs registered (1 cycle); stall is combinational; ID_EXE_FWD_EN enables forwarding.
module id_exe_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_Valid,
  input  logic              in_RegWrite,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_UseImm,
  input  logic [DATA_W-1:0] in_Op1,
  input  logic [DATA_W-1:0] in_Op2,
  input  logic [DATA_W-1:0] in_Imm,
  input  logic [OP_W-1:0]   in_Operation,
  input  logic [RA_W-1:0]   in_Rs,
  input  logic [RA_W-1:0]   in_Rt,
  input  logic [RA_W-1:0]   in_Rd,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_Result,
  input  logic              mem_RegWrite,
  input  logic              wb_RegWrite,
  input  logic [RA_W-1:0]   mem_Rd,
  input  logic [RA_W-1:0]   wb_Rd,
  input  logic [DATA_W-1:0] mem_Result,
  input  logic [DATA_W-1:0] wb_Result,
  output logic [DATA_W-1:0] out_ID_EXE_Op1,
  output logic [DATA_W-1:0] out_ID_EXE_Op2,
  output logic [DATA_W-1:0] out_ID_EXE_StoreData,
  output logic [OP_W-1:0]   out_ID_EXE_Operation,
  output logic [RA_W-1:0]   out_ID_EXE_Rd,
  output logic              out_ID_EXE_Valid,
  output logic              out_ID_EXE_RegWrite,
  output logic              out_ID_EXE_MemRead,
  output logic              out_ID_EXE_MemWrite,
  output logic              stall,
  output logic [15:0]       stall_cnt
);

  id_exe_t           q;
  id_exe_t           load;
  state_t            state;
  fwd_sel_t          rs_sel;
  fwd_sel_t          rt_sel;
  logic              hazard;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [15:0]       cnt;

  hazard_fwd_unit u_hazard_fwd (
    .id_valid      (in_Valid),
    .id_use_imm    (in_UseImm),
    .id_mem_write  (in_MemWrite),
    .id_rs         (in_Rs),
    .id_rt         (in_Rt),
    .ex_valid      (q.valid),
    .ex_reg_write  (q.reg_write),
    .ex_mem_read   (q.mem_read),
    .ex_rd         (q.rd),
    .mem_reg_write (mem_RegWrite),
    .mem_rd        (mem_Rd),
    .wb_reg_write  (wb_RegWrite),
    .wb_rd         (wb_Rd),
    .rs_sel        (rs_sel),
    .rt_sel        (rt_sel),
    .hazard        (hazard)
  );

  always_comb begin
    rs_data = in_Op1;
    unique case (rs_sel)
      FWD_EX:  rs_data = ex_Result;
      FWD_MEM: rs_data = mem_Result;
      FWD_WB:  rs_data = wb_Result;
      default: rs_data = in_Op1;
    endcase
  end

  always_comb begin
    rt_data = in_Op2;
    unique case (rt_sel)
      FWD_EX:  rt_data = ex_Result;
      FWD_MEM: rt_data = mem_Result;
      FWD_WB:  rt_data = wb_Result;
      default: rt_data = in_Op2;
    endcase
  end

  // An invalid ID slot is captured as a bubble so no stray control reaches EX.
  always_comb begin
    load = bubble();
    if (in_Valid) begin
      load.valid      = 1'b1;
      load.reg_write  = in_RegWrite;
      load.mem_read   = in_MemRead;
      load.mem_write  = in_MemWrite;
      load.operation  = in_Operation;
      load.rd         = in_Rd;
      load.op1        = rs_data;
      load.op2        = in_UseImm ? in_Imm : rt_data;
      load.store_data = rt_data;
    end
  end

  assign stall = hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      q     <= bubble();
      cnt   <= '0;
    end else begin
      if (stall && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
      if (flush) begin
        q     <= bubble();
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              q     <= bubble();
              state <= STALL;
            end else begin
              q <= load;
            end
          end
          STALL: begin
            // IF/ID has held the same instruction; release once the writer has moved on.
            if (hazard) begin
              q <= bubble();
            end else begin
              q     <= load;
              state <= RUN;
            end
          end
          default: begin
            q     <= bubble();
            state <= RUN;
          end
        endcase
      end
    end
  end

  assign out_ID_EXE_Op1       = q.op1;
  assign out_ID_EXE_Op2       = q.op2;
  assign out_ID_EXE_StoreData = q.store_data;
  assign out_ID_EXE_Operation = q.operation;
  assign out_ID_EXE_Rd        = q.rd;
  assign out_ID_EXE_Valid     = q.valid;
  assign out_ID_EXE_RegWrite  = q.reg_write;
  assign out_ID_EXE_MemRead   = q.mem_read;
  assign out_ID_EXE_MemWrite  = q.mem_write;
  assign stall_cnt            = cnt;

endmodule

// File: tb/tb_id_exe_stage.sv
// Randomized + directed bench for id_exe_stage against a writer-list reference model.
module tb_id_exe_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_Valid, in_RegWrite, in_MemRead, in_MemWrite, in_UseImm;
  logic [31:0] in_Op1, in_Op2, in_Imm;
  logic [5:0]  in_Operation;
  logic [4:0]  in_Rs, in_Rt, in_Rd;
  logic        flush;
  logic [31:0] ex_Result;
  logic        mem_RegWrite, wb_RegWrite;
  logic [4:0]  mem_Rd, wb_Rd;
  logic [31:0] mem_Result, wb_Result;
  logic [31:0] out_ID_EXE_Op1, out_ID_EXE_Op2, out_ID_EXE_StoreData;
  logic [5:0]  out_ID_EXE_Operation;
  logic [4:0]  out_ID_EXE_Rd;
  logic        out_ID_EXE_Valid, out_ID_EXE_RegWrite, out_ID_EXE_MemRead, out_ID_EXE_MemWrite;
  logic        stall;
  logic [15:0] stall_cnt;

  id_exe_stage dut (
    .clk(clk), .rst(rst),
    .in_Valid(in_Valid), .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_UseImm(in_UseImm),
    .in_Op1(in_Op1), .in_Op2(in_Op2), .in_Imm(in_Imm), .in_Operation(in_Operation),
    .in_Rs(in_Rs), .in_Rt(in_Rt), .in_Rd(in_Rd), .flush(flush),
    .ex_Result(ex_Result), .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
    .mem_Rd(mem_Rd), .wb_Rd(wb_Rd), .mem_Result(mem_Result), .wb_Result(wb_Result),
    .out_ID_EXE_Op1(out_ID_EXE_Op1), .out_ID_EXE_Op2(out_ID_EXE_Op2),
    .out_ID_EXE_StoreData(out_ID_EXE_StoreData), .out_ID_EXE_Operation(out_ID_EXE_Operation),
    .out_ID_EXE_Rd(out_ID_EXE_Rd), .out_ID_EXE_Valid(out_ID_EXE_Valid),
    .out_ID_EXE_RegWrite(out_ID_EXE_RegWrite), .out_ID_EXE_MemRead(out_ID_EXE_MemRead),
    .out_ID_EXE_MemWrite(out_ID_EXE_MemWrite), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage holds, described as the instruction it represents.
  typedef struct packed {
    logic        valid, rw, mr, mw;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] op1, op2, sd;
  } exp_t;

  exp_t        m, nxt;
  int unsigned mcnt;
  logic        nxt_stall;

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
`ifdef ID_EXE_FWD_EN
    logic        en[3];
    logic [4:0]  rd[3];
    logic [31:0] d[3];
    en[0] = m.valid && m.rw && !m.mr; rd[0] = m.rd;   d[0] = ex_Result;
    en[1] = mem_RegWrite;             rd[1] = mem_Rd; d[1] = mem_Result;
    en[2] = wb_RegWrite;              rd[2] = wb_Rd;  d[2] = wb_Result;
    for (int i = 0; i < 3; i++)
      if (r != 0 && en[i] && rd[i] == r) return d[i];
`endif
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic uses_rt;
    uses_rt = !in_UseImm || in_MemWrite;
`ifdef ID_EXE_FWD_EN
    return in_Valid && m.valid && m.mr && m.rd != 0 &&
           (in_Rs == m.rd || (uses_rt && in_Rt == m.rd));
`else
    begin
      logic       en[3];
      logic [4:0] rd[3];
      en[0] = m.valid && m.rw; rd[0] = m.rd;
      en[1] = mem_RegWrite;    rd[1] = mem_Rd;
      en[2] = wb_RegWrite;     rd[2] = wb_Rd;
      if (!in_Valid) return 1'b0;
      for (int i = 0; i < 3; i++)
        if (en[i] && rd[i] != 0 && (rd[i] == in_Rs || (uses_rt && rd[i] == in_Rt)))
          return 1'b1;
      return 1'b0;
    end
`endif
  endfunction

  // Compare process: outputs and stall checked every falling edge.
  initial begin
    m    = '0;
    mcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_valid", {31'd0, out_ID_EXE_Valid}, 32'd0);
        chk("rst_op1", out_ID_EXE_Op1, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
      end else begin
        chk("valid", {31'd0, out_ID_EXE_Valid}, {31'd0, m.valid});
        chk("regwrite", {31'd0, out_ID_EXE_RegWrite}, {31'd0, m.rw});
        chk("memread", {31'd0, out_ID_EXE_MemRead}, {31'd0, m.mr});
        chk("memwrite", {31'd0, out_ID_EXE_MemWrite}, {31'd0, m.mw});
        chk("operation", {26'd0, out_ID_EXE_Operation}, {26'd0, m.op});
        chk("rd", {27'd0, out_ID_EXE_Rd}, {27'd0, m.rd});
        chk("op1", out_ID_EXE_Op1, m.op1);
        chk("op2", out_ID_EXE_Op2, m.op2);
        chk("storedata", out_ID_EXE_StoreData, m.sd);
        chk("stall_cnt", {16'd0, stall_cnt}, mcnt);
        chk("stall", {31'd0, stall}, {31'd0, model_hazard() && !flush});
        nxt       = '0;
        nxt_stall = 1'b0;
        if (!flush) begin
          if (model_hazard()) nxt_stall = 1'b1;
          else if (in_Valid) begin
            nxt.valid = 1'b1;
            nxt.rw    = in_RegWrite;
            nxt.mr    = in_MemRead;
            nxt.mw    = in_MemWrite;
            nxt.op    = in_Operation;
            nxt.rd    = in_Rd;
            nxt.op1   = model_fwd(in_Rs, in_Op1);
            nxt.sd    = model_fwd(in_Rt, in_Op2);
            nxt.op2   = in_UseImm ? in_Imm : nxt.sd;
          end
        end
      end
      @(posedge clk);
      if (rst) begin
        m    = '0;
        mcnt = 0;
      end else begin
        m = nxt;
        if (nxt_stall && mcnt < 32'hFFFF) mcnt++;
      end
    end
  end

  logic stall_edge;
  always @(posedge clk) stall_edge <= stall;

  task automatic idle();
    in_Valid = 0; in_RegWrite = 0; in_MemRead = 0; in_MemWrite = 0; in_UseImm = 0;
    in_Op1 = 0; in_Op2 = 0; in_Imm = 0; in_Operation = 0;
    in_Rs = 0; in_Rt = 0; in_Rd = 0; flush = 0; ex_Result = 0;
    mem_RegWrite = 0; wb_RegWrite = 0; mem_Rd = 0; wb_Rd = 0;
    mem_Result = 0; wb_Result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic set_id(input logic rw, input logic mr, input logic use_imm,
                        input logic [31:0] op1, input logic [31:0] op2,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    in_Valid = 1; in_RegWrite = rw; in_MemRead = mr; in_MemWrite = 0; in_UseImm = use_imm;
    in_Op1 = op1; in_Op2 = op2; in_Imm = 32'h0000_0010; in_Operation = FUNCT_ADD;
    in_Rs = rs; in_Rt = rt; in_Rd = rd;
  endtask

  task automatic stall_is(input string name, input logic exp);
    @(negedge clk);
    #1;
    chk(name, {31'd0, stall}, {31'd0, exp});
  endtask

  task automatic rand_id();
    in_Valid     = ($urandom_range(0, 7) != 0);
    in_RegWrite  = 1'($urandom_range(0, 1));
    in_MemRead   = ($urandom_range(0, 3) == 0);
    in_MemWrite  = ($urandom_range(0, 5) == 0);
    in_UseImm    = 1'($urandom_range(0, 1));
    in_Op1       = $urandom;
    in_Op2       = $urandom;
    in_Imm       = $urandom;
    in_Operation = ($urandom_range(0, 1) != 0) ? FUNCT_ADD : FUNCT_SUB;
    in_Rs        = 5'($urandom_range(0, 3));
    in_Rt        = 5'($urandom_range(0, 3));
    in_Rd        = 5'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_valid", {31'd0, out_ID_EXE_Valid}, 32'd0);
    chk("reset_operation", {26'd0, out_ID_EXE_Operation}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);

    // Plain load into EX.
    set_id(1, 0, 0, 32'h01, 32'h0A, 5'd1, 5'd2, 5'd5);
    stall_is("basic_stall", 1'b0);
    tick();
    chk("basic_op1", out_ID_EXE_Op1, 32'h01);
    chk("basic_op2", out_ID_EXE_Op2, 32'h0A);
    chk("basic_operation", {26'd0, out_ID_EXE_Operation}, 32'h20);
    chk("basic_valid", {31'd0, out_ID_EXE_Valid}, 32'd1);

    // EX forward beats MEM for the same register.
    do_reset();
    set_id(1, 0, 0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(1, 0, 0, 32'h77, 32'h2, 5'd3, 5'd2, 5'd6);
    ex_Result = 32'h0B; mem_RegWrite = 1; mem_Rd = 5'd3; mem_Result = 32'h55;
`ifdef ID_EXE_FWD_EN
    tick();
    chk("ex_fwd_op1", out_ID_EXE_Op1, 32'h0B);
`else
    stall_is("raw_ex_stall", 1'b1);
`endif

    // Load-use.
    do_reset();
    set_id(1, 1, 1, 32'h1, 32'h0, 5'd1, 5'd0, 5'd4);
    tick();
    set_id(1, 0, 0, 32'h1, 32'h99, 5'd1, 5'd4, 5'd6);
    stall_is("lu_stall", 1'b1);
    tick();
    chk("lu_bubble", {31'd0, out_ID_EXE_Valid}, 32'd0);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
`ifdef ID_EXE_FWD_EN
    mem_RegWrite = 1; mem_Rd = 5'd4; mem_Result = 32'h1234;
    stall_is("lu_release", 1'b0);
    tick();
    chk("lu_mem_fwd", out_ID_EXE_Op2, 32'h1234);
    chk("lu_valid", {31'd0, out_ID_EXE_Valid}, 32'd1);
    chk("lu_cnt_after", {16'd0, stall_cnt}, 32'd1);
`else
    mem_RegWrite = 1; mem_Rd = 5'd4;
    stall_is("raw_mem_stall", 1'b1);
    tick();
    mem_RegWrite = 0; wb_RegWrite = 1; wb_Rd = 5'd4;
    stall_is("raw_wb_stall", 1'b1);
    tick();
    wb_RegWrite = 0;
    stall_is("raw_release", 1'b0);
    tick();
    chk("raw_valid", {31'd0, out_ID_EXE_Valid}, 32'd1);
    chk("raw_op2", out_ID_EXE_Op2, 32'h99);
    chk("raw_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // r0 never forwarded.
    do_reset();
    set_id(1, 0, 0, 32'h42, 32'h3, 5'd0, 5'd2, 5'd7);
    mem_RegWrite = 1; mem_Rd = 5'd0; mem_Result = 32'hFFFF;
    tick();
    chk("r0_op1", out_ID_EXE_Op1, 32'h42);

    // Flush beats a load-use hazard.
    do_reset();
    set_id(1, 1, 1, 32'h1, 32'h0, 5'd1, 5'd0, 5'd4);
    tick();
    set_id(1, 0, 0, 32'h1, 32'h2, 5'd1, 5'd4, 5'd6);
    flush = 1;
    stall_is("flush_stall", 1'b0);
    tick();
    chk("flush_bubble", {31'd0, out_ID_EXE_Valid}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, 32'd0);
    flush = 0;

    // Reset while in STALL.
    do_reset();
    set_id(1, 1, 1, 32'h1, 32'h0, 5'd1, 5'd0, 5'd4);
    tick();
    set_id(1, 0, 0, 32'h1, 32'h2, 5'd4, 5'd2, 5'd6);
    stall_is("pre_rst_stall", 1'b1);
    tick();
    chk("pre_rst_cnt", {16'd0, stall_cnt}, 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_ID_EXE_Valid}, 32'd0);
    tick();
    rst = 0;
    set_id(1, 0, 0, 32'h5, 32'h6, 5'd1, 5'd2, 5'd3);
    tick();
    chk("post_rst_load", out_ID_EXE_Op1, 32'h5);

    // Randomized traffic; IF/ID holds its instruction whenever stall was seen at the edge.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!stall_edge) rand_id();
      flush        = ($urandom_range(0, 15) == 0);
      ex_Result    = $urandom;
      mem_RegWrite = 1'($urandom_range(0, 1));
      mem_Rd       = 5'($urandom_range(0, 3));
      mem_Result   = $urandom;
      wb_RegWrite  = 1'($urandom_range(0, 1));
      wb_Rd        = 5'($urandom_range(0, 3));
      wb_Result    = $urandom;
      tick();
    end

    idle();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
